// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared state and mode encodings for the CRC engine
package crc_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } crc_state_e;

    // Job mode encoding
    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/crc_div_step.sv
// rtl/crc_div_step.sv - one combinational step of MSB-first polynomial division
//
// Ports:
//   rem_i   current remainder
//   bit_i   next message bit shifted into the remainder
//   poly_i  generator polynomial without its implied leading 1
//   rem_o   remainder after this step
module crc_div_step #(
    parameter int CRC_W = 3
) (
    input  logic [CRC_W-1:0] rem_i,
    input  logic             bit_i,
    input  logic [CRC_W-1:0] poly_i,
    output logic [CRC_W-1:0] rem_o
);

    // The bit falling off the top decides whether the divisor is subtracted.
    assign rem_o = {rem_i[CRC_W-2:0], bit_i} ^ (rem_i[CRC_W-1] ? poly_i : {CRC_W{1'b0}});

endmodule

// File: rtl/crc_engine.sv
// rtl/crc_engine.sv - bit-serial CRC generator/checker with valid/ready handshakes
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   job request handshake (accepted only in IDLE)
//   mode                  0 = generate, 1 = check
//   poly                  generator polynomial, poly[CRC_W] implied and ignored
//   data_in               message word, MSB first
//   crc_in                received CRC, appended as the tail in check mode
//   out_valid / out_ready result handshake (held in DONE)
//   crc_out, crc_ok       final remainder and check verdict, registered
//   busy                  job in progress or result pending
module crc_engine
    import crc_pkg::*;
#(
    parameter int CRC_W  = 3,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic [CRC_W:0]    poly,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CRC_W-1:0]  crc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_ok,
    output logic              busy
);

    localparam int SW    = DATA_W + CRC_W;
    localparam int CNT_W = $clog2(SW + 1);

    crc_state_e        state_q, state_d;
    logic              mode_q, mode_d;
    logic [CRC_W-1:0]  poly_q, poly_d;
    logic [CRC_W-1:0]  rem_q, rem_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic              ok_q, ok_d;
    logic [SW-1:0]     sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CRC_W-1:0]  rem_step;
    logic [CRC_W-1:0]  tail;

    // The polynomial's leading coefficient is implied; keep it visibly unused.
    logic unused_poly_msb;
    assign unused_poly_msb = poly[CRC_W];

    assign tail = (mode == MODE_CHK) ? crc_in : {CRC_W{1'b0}};

    crc_div_step #(.CRC_W(CRC_W)) u_step (
        .rem_i  (rem_q),
        .bit_i  (sh_q[SW-1]),
        .poly_i (poly_q),
        .rem_o  (rem_step)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        poly_d  = poly_q;
        rem_d   = rem_q;
        crc_d   = crc_q;
        ok_d    = ok_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mode_d  = mode;
                    poly_d  = poly[CRC_W-1:0];
                    sh_d    = {data_in, tail};
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                rem_d = rem_step;
                sh_d  = {sh_q[SW-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                // Last bit: capture the result straight from the step so the
                // outputs are already valid in the first DONE cycle.
                if (cnt_q == CNT_W'(SW - 1)) begin
                    crc_d   = rem_step;
                    ok_d    = (mode_q == MODE_CHK) && (rem_step == '0);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_GEN;
            poly_q  <= '0;
            rem_q   <= '0;
            crc_q   <= '0;
            ok_q    <= 1'b0;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            poly_q  <= poly_d;
            rem_q   <= rem_d;
            crc_q   <= crc_d;
            ok_q    <= ok_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign crc_out   = crc_q;
    assign crc_ok    = ok_q;

endmodule

// File: tb/tb_crc_engine.sv
// tb/tb_crc_engine.sv - self-checking bench for crc_engine
module tb_crc_engine;
    import crc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       in_valid = 1'b0, in_ready, mode = 1'b0, out_valid, out_ready = 1'b0, crc_ok, busy;
    logic [3:0] poly = '0, data_in = '0;
    logic [2:0] crc_in = '0, crc_out;

    crc_engine dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .poly(poly), .data_in(data_in), .crc_in(crc_in),
        .out_valid(out_valid), .out_ready(out_ready), .crc_out(crc_out),
        .crc_ok(crc_ok), .busy(busy)
    );

    // CRC-8 / 16-bit data instance
    logic        in_valid8 = 1'b0, in_ready8, mode8 = 1'b0, out_valid8, out_ready8 = 1'b0, crc_ok8, busy8;
    logic [8:0]  poly8 = '0;
    logic [15:0] data8 = '0;
    logic [7:0]  crc_in8 = '0, crc_out8;

    crc_engine #(.CRC_W(8), .DATA_W(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .mode(mode8), .poly(poly8), .data_in(data8), .crc_in(crc_in8),
        .out_valid(out_valid8), .out_ready(out_ready8), .crc_out(crc_out8),
        .crc_ok(crc_ok8), .busy(busy8)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       mode;
        logic [3:0] poly;
        logic [3:0] data;
        logic [2:0] crc;
        logic [2:0] exp_crc;
        logic       exp_ok;
    } vec_t;

    // Run one job on the default instance; result is left pending in DONE.
    task automatic start_and_wait(input logic m, input logic [3:0] p, input logic [3:0] d,
                                  input logic [2:0] c, output int lat);
        mode = m; poly = p; data_in = d; crc_in = c; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, ".in_ready_after"}, in_ready, 1'b1);
        chk({name, ".out_valid_after"}, out_valid, 1'b0);
    endtask

    function automatic logic [7:0] crc8_model(input logic [15:0] d);
        logic [7:0] c = 8'h00;
        for (int i = 15; i >= 0; i--) begin
            logic fb = c[7] ^ d[i];
            c = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   lat;
        logic [7:0] gold;

        vecs[0] = '{MODE_GEN, 4'b1011, 4'b1101, 3'b000, 3'b001, 1'b0};
        vecs[1] = '{MODE_CHK, 4'b1011, 4'b1101, 3'b001, 3'b000, 1'b1};
        vecs[2] = '{MODE_CHK, 4'b1011, 4'b1101, 3'b011, 3'b010, 1'b0};
        vecs[3] = '{MODE_GEN, 4'b1011, 4'b0000, 3'b111, 3'b000, 1'b0};
        vecs[4] = '{MODE_GEN, 4'b1011, 4'b1000, 3'b010, 3'b101, 1'b0};
        vecs[5] = '{MODE_CHK, 4'b1011, 4'b1000, 3'b101, 3'b000, 1'b1};
        vecs[6] = '{MODE_CHK, 4'b1000, 4'b1101, 3'b101, 3'b101, 1'b0};
        vecs[7] = '{MODE_GEN, 4'b0011, 4'b1101, 3'b000, 3'b001, 1'b0};

        // Reset state
        #1;
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.crc_out", crc_out, 3'b000);
        chk("rst.crc_ok", crc_ok, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Table-driven jobs
        for (int i = 0; i < 8; i++) begin
            start_and_wait(vecs[i].mode, vecs[i].poly, vecs[i].data, vecs[i].crc, lat);
            chk($sformatf("vec%0d.latency", i), lat, 7);
            chk($sformatf("vec%0d.crc_out", i), crc_out, vecs[i].exp_crc);
            chk($sformatf("vec%0d.crc_ok", i), crc_ok, vecs[i].exp_ok);
            chk($sformatf("vec%0d.busy", i), busy, 1'b1);
            chk($sformatf("vec%0d.in_ready", i), in_ready, 1'b0);
            release_result($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while inputs churn and in_valid pulses
        start_and_wait(MODE_GEN, 4'b1011, 4'b1101, 3'b000, lat);
        chk("bp.latency", lat, 7);
        for (int k = 0; k < 5; k++) begin
            data_in = 4'(k * 3 + 2);
            poly = 4'(k + 9);
            mode = k[0];
            in_valid = ~k[0];
            step();
            chk($sformatf("bp%0d.out_valid", k), out_valid, 1'b1);
            chk($sformatf("bp%0d.crc_out", k), crc_out, 3'b001);
            chk($sformatf("bp%0d.crc_ok", k), crc_ok, 1'b0);
            chk($sformatf("bp%0d.in_ready", k), in_ready, 1'b0);
        end
        in_valid = 1'b0;
        release_result("bp");
        step();
        chk("bp.no_second_accept", busy, 1'b0);

        // out_ready while idle is harmless
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("idle_ready.busy", busy, 1'b0);

        // Reset mid-job: leave a nonzero result registered first
        start_and_wait(MODE_GEN, 4'b1011, 4'b1000, 3'b000, lat);
        chk("prerst.crc_out", crc_out, 3'b101);
        release_result("prerst");
        mode = MODE_CHK; poly = 4'b1011; data_in = 4'b1101; crc_in = 3'b011; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        chk("midrst.busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", out_valid, 1'b0);
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.crc_out", crc_out, 3'b000);
        chk("midrst.crc_ok", crc_ok, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        chk("midrst.in_ready", in_ready, 1'b1);
        start_and_wait(MODE_GEN, 4'b1011, 4'b1101, 3'b000, lat);
        chk("postrst.latency", lat, 7);
        chk("postrst.crc_out", crc_out, 3'b001);
        chk("postrst.crc_ok", crc_ok, 1'b0);
        release_result("postrst");

        // Parametric CRC-8 over 16-bit data
        gold = crc8_model(16'h3132);
        for (int pass = 0; pass < 2; pass++) begin
            mode8 = pass[0]; poly8 = 9'h107; data8 = 16'h3132; crc_in8 = gold; in_valid8 = 1'b1;
            step();
            in_valid8 = 1'b0;
            lat = 0;
            while (!out_valid8 && lat < 200) begin
                step();
                lat++;
            end
            chk($sformatf("crc8_%0d.latency", pass), lat, 24);
            chk($sformatf("crc8_%0d.crc_out", pass), crc_out8, (pass == 0) ? gold : 8'h00);
            chk($sformatf("crc8_%0d.crc_ok", pass), crc_ok8, (pass == 0) ? 1'b0 : 1'b1);
            out_ready8 = 1'b1;
            step();
            out_ready8 = 1'b0;
            chk($sformatf("crc8_%0d.in_ready", pass), in_ready8, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
